// File: rtl/apb2reg_native_if_bridge.sv
// APB3 slave to reg_native_if bridge: one outstanding request, registered outputs,
// and an optional watchdog that answers PSLVERR when the register tree stays silent.
module apb2reg_native_if_bridge #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  req_vld,
    input  logic                  ack_vld,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  timeout_evt
);

    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RESP     = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_vld_q, req_vld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  timeout_evt_q, timeout_evt_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_vld_d     = 1'b0;
        addr_d        = addr_q;
        wr_en_d       = wr_en_q;
        rd_en_d       = rd_en_q;
        wr_data_d     = wr_data_q;
        pready_d      = 1'b0;
        prdata_d      = '0;
        pslverr_d     = 1'b0;
        timeout_evt_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a genuine setup phase starts a request; psel with penable here is ignored.
                if (psel && !penable) begin
                    state_d   = WAIT_ACK;
                    req_vld_d = 1'b1;
                    addr_d    = paddr;
                    wr_data_d = pwdata;
                    wr_en_d   = pwrite;
                    rd_en_d   = !pwrite;
                    cnt_d     = '0;
                end
            end
            WAIT_ACK: begin
                if (ack_vld) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    prdata_d  = rd_en_q ? rd_data : '0;
                    addr_d    = '0;
                    wr_en_d   = 1'b0;
                    rd_en_d   = 1'b0;
                    wr_data_d = '0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d       = RESP;
                    pready_d      = 1'b1;
                    pslverr_d     = 1'b1;
                    timeout_evt_d = 1'b1;
                    addr_d        = '0;
                    wr_en_d       = 1'b0;
                    rd_en_d       = 1'b0;
                    wr_data_d     = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_vld_q     <= 1'b0;
            addr_q        <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_data_q     <= '0;
            pready_q      <= 1'b0;
            prdata_q      <= '0;
            pslverr_q     <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_vld_q     <= req_vld_d;
            addr_q        <= addr_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            wr_data_q     <= wr_data_d;
            pready_q      <= pready_d;
            prdata_q      <= prdata_d;
            pslverr_q     <= pslverr_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign pready      = pready_q;
    assign prdata      = prdata_q;
    assign pslverr     = pslverr_q;
    assign req_vld     = req_vld_q;
    assign addr        = addr_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign wr_data     = wr_data_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_apb2reg_native_if_bridge.sv
// Bench for apb2reg_native_if_bridge: instance 0 has a 4-cycle watchdog, instance 1 has it disabled.
module tb_apb2reg_native_if_bridge;

    localparam int AW = 64;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          psel[2], penable[2], pwrite[2], ack_vld[2];
    logic [AW-1:0] paddr[2];
    logic [DW-1:0] pwdata[2], rd_data[2];
    logic          pready[2], pslverr[2], req_vld[2], wr_en[2], rd_en[2], timeout_evt[2];
    logic [DW-1:0] prdata[2], wr_data[2];
    logic [AW-1:0] addr[2];

    int vectors = 0;
    int miscompares = 0;

    apb2reg_native_if_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut_to4 (
        .clk(clk), .rst_n(rst_n),
        .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
        .req_vld(req_vld[0]), .ack_vld(ack_vld[0]), .addr(addr[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .wr_data(wr_data[0]),
        .rd_data(rd_data[0]), .timeout_evt(timeout_evt[0])
    );

    apb2reg_native_if_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_to0 (
        .clk(clk), .rst_n(rst_n),
        .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
        .req_vld(req_vld[1]), .ack_vld(ack_vld[1]), .addr(addr[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .wr_data(wr_data[1]),
        .rd_data(rd_data[1]), .timeout_evt(timeout_evt[1])
    );

    function automatic int to_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[dut%0d] observed=0x%0h expected=0x%0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int i);
        chk({tag, "_ctl"}, i, {58'd0, pready[i], pslverr[i], req_vld[i], wr_en[i], rd_en[i], timeout_evt[i]}, 64'd0);
        chk({tag, "_addr"}, i, addr[i], 64'd0);
        chk({tag, "_wdata"}, i, {32'd0, wr_data[i]}, 64'd0);
        chk({tag, "_prdata"}, i, {32'd0, prdata[i]}, 64'd0);
    endtask

    task automatic idle_inputs(input int i);
        psel[i]    = 1'b0;
        penable[i] = 1'b0;
        pwrite[i]  = 1'b0;
        paddr[i]   = '0;
        pwdata[i]  = '0;
        ack_vld[i] = 1'b0;
        rd_data[i] = $urandom;
    endtask

    // Reference model of one transfer: ack after k WAIT_ACK cycles past the request cycle
    // (k beyond the watchdog window means the bridge times out). Called right after a negedge.
    task automatic xfer(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int k, input logic [DW-1:0] rv, input bit drop);
        int to;
        int respc;
        bit timed_out;
        logic [DW-1:0] exp_rd;
        to        = to_of(i);
        timed_out = (to != 0) && (k > to - 1);
        respc     = timed_out ? to + 1 : 2 + k;
        exp_rd    = (timed_out || wr) ? '0 : rv;
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = d;
        ack_vld[i] = 1'b0;
        for (int c = 1; c <= respc + 1; c++) begin
            @(negedge clk);
            if (c < respc) begin
                chk("req_vld", i, {63'd0, req_vld[i]}, {63'd0, c == 1});
                chk("addr_hold", i, addr[i], a);
                chk("wdata_hold", i, {32'd0, wr_data[i]}, {32'd0, d});
                chk("dir", i, {62'd0, wr_en[i], rd_en[i]}, {62'd0, wr, !wr});
                chk("wait_pready", i, {62'd0, pready[i], timeout_evt[i]}, 64'd0);
            end else if (c == respc) begin
                chk("resp_pready", i, {63'd0, pready[i]}, 64'd1);
                chk("resp_pslverr", i, {63'd0, pslverr[i]}, {63'd0, timed_out});
                chk("resp_prdata", i, {32'd0, prdata[i]}, {32'd0, exp_rd});
                chk("resp_tmo_evt", i, {63'd0, timeout_evt[i]}, {63'd0, timed_out});
                chk("resp_ds", i, {addr[i][62:0], req_vld[i]} | {32'd0, wr_data[i]} | {62'd0, wr_en[i], rd_en[i]}, 64'd0);
            end else begin
                chk_quiet("after_resp", i);
            end
            psel[i]    = (c <= respc) && !(drop && c >= 2 && c < respc);
            penable[i] = psel[i];
            ack_vld[i] = (c == 1 + k) && (c <= respc);
            rd_data[i] = ack_vld[i] ? rv : $urandom;
        end
        ack_vld[i] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (3) @(negedge clk);
        chk_quiet("reset", 0);
        chk_quiet("reset", 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Write acked in its request cycle.
        xfer(0, 1'b1, 64'h118, 32'hA5A5_0001, 0, 32'h0, 1'b0);
        // Read with 5-cycle ack delay on the instance without watchdog.
        xfer(1, 1'b0, 64'h200, 32'h0, 5, 32'h1234_5678, 1'b0);

        // Timeout, then a late ack that must be ignored.
        xfer(0, 1'b0, 64'h300, 32'h0, 100, 32'h0, 1'b0);
        for (int c = 7; c <= 10; c++) begin
            @(negedge clk);
            chk_quiet("late_ack", 0);
            ack_vld[0] = (c == 8);
            rd_data[0] = 32'hDEAD_BEEF;
        end
        ack_vld[0] = 1'b0;

        // Ack coincident with the last watchdog cycle: ack wins.
        xfer(0, 1'b0, 64'h400, 32'h0, 3, 32'h0000_CAFE, 1'b0);

        // Back-to-back writes, next setup in the cycle after pready.
        xfer(1, 1'b1, 64'h10, 32'h1111_1111, 0, 32'h0, 1'b0);
        xfer(1, 1'b1, 64'h14, 32'h2222_2222, 2, 32'h0, 1'b0);

        // psel with penable in IDLE, plus stray ack in IDLE: no request.
        psel[0] = 1'b1; penable[0] = 1'b1; ack_vld[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_quiet("idle_violation", 0);
        end
        idle_inputs(0);
        @(negedge clk);

        // Randomized transfers, including master dropping psel mid-transfer.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 2; i++) begin
                xfer(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
                     int'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        // Disabled watchdog: withhold ack for 1000 cycles.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 64'hABC0; pwdata[1] = '0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 2) psel[1] = 1'b1;
            penable[1] = 1'b1;
            chk("noto_pready", 1, {62'd0, pready[1], timeout_evt[1]}, 64'd0);
            chk("noto_rd_en", 1, {63'd0, rd_en[1]}, 64'd1);
        end

        // Asynchronous reset in WAIT_ACK.
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("async_reset", 1);
        idle_inputs(1);
        @(negedge clk);
        rst_n = 1'b1;
        ack_vld[1] = 1'b1;
        rd_data[1] = 32'h5555_AAAA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ack_vld[1] = 1'b0;
            chk_quiet("stray_ack", 1);
        end
        xfer(1, 1'b0, 64'h500, 32'h0, 1, 32'h7777_0001, 1'b0);
        xfer(0, 1'b1, 64'h504, 32'h0BAD_F00D, 2, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb2reg_native_if_bridge.md
Name: apb2reg_native_if_bridge

Overview:
- Root-side front end of the register network. Converts an APB3 slave transfer into one reg_native_if request, drives it into the root register dispatcher, and waits for ack_vld.
- Returns the result to APB with PREADY, PRDATA and PSLVERR.
- A programmable watchdog completes the APB transfer with PSLVERR if the downstream tree never acknowledges.
- At most one transaction is outstanding.

Parameters:
ADDR_WIDTH, 64, width of paddr and of the downstream absolute address
DATA_WIDTH, 32, width of the data buses
TIMEOUT_CYCLES, 255, maximum WAIT_ACK cycles before an error response; 0 disables the timeout

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB direction, 1 = write
paddr  input  ADDR_WIDTH  APB absolute byte address
pwdata  input  DATA_WIDTH  APB write data
pready  output  1  APB transfer complete
prdata  output  DATA_WIDTH  APB read data
pslverr  output  1  APB error, valid only with pready
req_vld  output  1  downstream request strobe, one-cycle pulse
ack_vld  input  1  downstream acknowledge, one-cycle pulse
addr  output  ADDR_WIDTH  downstream absolute address, passed through unmodified
wr_en  output  1  downstream write
rd_en  output  1  downstream read
wr_data  output  DATA_WIDTH  downstream write data
rd_data  input  DATA_WIDTH  downstream read data, valid with ack_vld
timeout_evt  output  1  one-cycle pulse when a transaction is ended by the timeout

Behaviour:
- Reset value of every output is 0. The FSM is in IDLE and the timeout counter is 0.
- All outputs are registered.
- The FSM has three states: IDLE, WAIT_ACK, RESP.
- IDLE:
  - Setup phase is psel=1 and penable=0 at a clock edge.
  - On setup, latch paddr/pwdata into addr/wr_data and set wr_en=pwrite, rd_en=~pwrite.
  - Assert req_vld for the next cycle only, clear the counter, and go to WAIT_ACK.
  - psel=1 with penable=1 in IDLE is a protocol violation: ignore it and do not issue a request.
- WAIT_ACK:
  - addr, wr_en, rd_en and wr_data hold stable until the FSM leaves WAIT_ACK, then return to 0.
  - req_vld is high only in the first WAIT_ACK cycle.
  - ack_vld is accepted in any WAIT_ACK cycle, including the req_vld cycle.
  - On ack: capture prdata = rd_rd_data for reads, or 0 for writes; set pslverr=0; go to RESP.
  - With no ack, the counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter == TIMEOUT_CYCLES-1 with no ack: prdata=0, pslverr=1, pulse timeout_evt, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP:
  - pready=1 for exactly one cycle, with prdata/pslverr valid; then go to IDLE.
  - prdata and pslverr return to 0 in the following cycle.
  - A new setup phase is accepted in the cycle after RESP at the earliest.
- Latency:
  - Setup at cycle T, req_vld at T+1.
  - Ack at T+1+k gives pready at T+2+k.
  - Minimum APB transfer is 3 cycles.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- An ack_vld arriving in IDLE or RESP (a late ack after a timeout) is ignored and does not disturb state.
- psel or penable dropping while in WAIT_ACK or RESP (master violation) does not abort: the transaction completes and pready still pulses.
- Asserting rst_n low mid-transaction returns everything to reset values immediately. No APB response is produced, and any later ack for the aborted request is ignored.
- wr_en and rd_en are never both 1.

Test Plan:
- Write, ack in the req cycle. Setup at T with paddr=0x118, pwdata=0xA5A5_0001, pwrite=1. Expect: req_vld=1, wr_en=1, addr=0x118, wr_data=0xA5A5_0001 at T+1. Drive ack_vld at T+1. Expect pready=1, pslverr=0 at T+2, and all downstream outputs 0 at T+2.
- Read with 5-cycle ack delay. Read at paddr=0x200, ack at T+6 with rd_data=0x1234_5678. Expect: req_vld high only at T+1; addr held through T+6; pready=1, prdata=0x1234_5678 at T+7, then prdata=0.
- Timeout. TIMEOUT_CYCLES=4, read, never ack. Expect: timeout_evt and WAIT_ACK exit after 4 WAIT_ACK cycles; pready=1, pslverr=1, prdata=0 at T+5. Inject ack at T+8: ignored, no second pready.
- Ack coincident with timeout. TIMEOUT_CYCLES=4, ack on the 4th WAIT_ACK cycle with rd_data=0xCAFE. Expect pslverr=0, prdata=0xCAFE, timeout_evt=0.
- Back-to-back transfers and disabled timeout. TIMEOUT_CYCLES=0, two writes with setup in the cycle after pready. Expect two req_vld pulses spaced by 3 cycles minimum. Withhold ack for 1000 cycles: no timeout, pready stays 0.
- Reset mid-op. Assert rst_n low during WAIT_ACK. Expect all outputs 0 asynchronously. After release, a stray ack_vld=1 produces no pready, and the next transfer completes normally.
